// File: rtl/noc_ejection_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : noc_ejection_unit (with noc_pkg flit format)                 |
// | Description : Local-port depacketizer. Reassembles HEAD/BODY/TAIL or       |
// |               HEADTAIL flits into one message with head fields, buffered   |
// |               body/tail payloads, length, truncation and misroute flags.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package noc_pkg;
  localparam int DEST_ADDR_SIZE_X  = 4;
  localparam int DEST_ADDR_SIZE_Y  = 4;
  // Head payload carries {src_x, src_y, 64-bit head data}.
  localparam int HEAD_PAYLOAD_SIZE = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + 64;
  localparam int FLIT_DATA_SIZE    = HEAD_PAYLOAD_SIZE;

  localparam logic [1:0] FLIT_HEAD     = 2'd0;
  localparam logic [1:0] FLIT_BODY     = 2'd1;
  localparam logic [1:0] FLIT_TAIL     = 2'd2;
  localparam logic [1:0] FLIT_HEADTAIL = 2'd3;

  typedef union packed {
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
    logic [FLIT_DATA_SIZE-1:0]    bt_pl;
  } flit_payload_t;

  typedef struct packed {
    logic [1:0]                  flit_type;
    logic [DEST_ADDR_SIZE_X-1:0] x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
    flit_payload_t               payload;
  } flit_novc_t;
endpackage

module noc_ejection_unit
  import noc_pkg::*;
#(
  parameter int LOCAL_X  = 0,
  parameter int LOCAL_Y  = 0,
  parameter int MAX_BODY = 4,
  localparam int LW      = $clog2(MAX_BODY + 1)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flit_valid_i,
  input  logic [$bits(flit_novc_t)-1:0]      flit_i,
  output logic                               flit_ready_o,
  output logic                               msg_valid_o,
  input  logic                               msg_ready_i,
  output logic [DEST_ADDR_SIZE_X-1:0]        msg_src_x_o,
  output logic [DEST_ADDR_SIZE_Y-1:0]        msg_src_y_o,
  output logic [63:0]                        msg_head_o,
  output logic [MAX_BODY*FLIT_DATA_SIZE-1:0] msg_body_o,
  output logic [LW-1:0]                      msg_len_o,
  output logic                               msg_trunc_o,
  output logic                               msg_misroute_o,
  output logic                               err_orphan_o,
  output logic                               err_head_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DELIVER = 2'd2;

  localparam logic [DEST_ADDR_SIZE_X-1:0] LOC_X   = DEST_ADDR_SIZE_X'(LOCAL_X);
  localparam logic [DEST_ADDR_SIZE_Y-1:0] LOC_Y   = DEST_ADDR_SIZE_Y'(LOCAL_Y);
  localparam logic [LW-1:0]               LEN_MAX = LW'(MAX_BODY);

  logic [1:0] state;
  logic [1:0] next_state;
  flit_novc_t flit;
  logic       accept;
  logic       is_head;
  logic       is_last;

  assign flit    = flit_novc_t'(flit_i);
  assign accept  = flit_valid_i && flit_ready_o;
  assign is_head = (flit.flit_type == FLIT_HEAD) || (flit.flit_type == FLIT_HEADTAIL);
  assign is_last = (flit.flit_type == FLIT_TAIL) || (flit.flit_type == FLIT_HEADTAIL);

  // State register; ready tracks next state so it is low for the whole delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      flit_ready_o <= 1'b0;
    end else begin
      state        <= next_state;
      flit_ready_o <= (next_state != S_DELIVER);
    end
  end

  // Next-state: a head restarts from any non-delivery state, a last flit delivers.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept && is_head) begin
          next_state = is_last ? S_DELIVER : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (accept && is_last) begin
          next_state = S_DELIVER;
        end
      end
      S_DELIVER: begin
        if (msg_ready_i) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Output decode: a message is presented only while holding it in DELIVER.
  always_comb begin
    msg_valid_o = (state == S_DELIVER);
  end

  // Datapath: head capture, body storage with saturation, error pulses, clear on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_src_x_o    <= '0;
      msg_src_y_o    <= '0;
      msg_head_o     <= '0;
      msg_body_o     <= '0;
      msg_len_o      <= '0;
      msg_trunc_o    <= 1'b0;
      msg_misroute_o <= 1'b0;
      err_orphan_o   <= 1'b0;
      err_head_o     <= 1'b0;
    end else begin
      err_orphan_o <= 1'b0;
      err_head_o   <= 1'b0;
      if (accept) begin
        if (is_head) begin
          // A head inside an open packet discards the partial packet first.
          msg_src_x_o    <= flit.payload.head_pl[HEAD_PAYLOAD_SIZE-1 -: DEST_ADDR_SIZE_X];
          msg_src_y_o    <= flit.payload.head_pl[HEAD_PAYLOAD_SIZE-DEST_ADDR_SIZE_X-1 -: DEST_ADDR_SIZE_Y];
          msg_head_o     <= flit.payload.head_pl[63:0];
          msg_body_o     <= '0;
          msg_len_o      <= '0;
          msg_trunc_o    <= 1'b0;
          msg_misroute_o <= (flit.x_dest != LOC_X) || (flit.y_dest != LOC_Y);
          err_head_o     <= (state == S_COLLECT);
        end else if (state == S_IDLE) begin
          err_orphan_o <= 1'b1;
        end else if (state == S_COLLECT) begin
          if (msg_len_o < LEN_MAX) begin
            for (int k = 0; k < MAX_BODY; k++) begin
              if (msg_len_o == LW'(k)) begin
                msg_body_o[k*FLIT_DATA_SIZE +: FLIT_DATA_SIZE] <= flit.payload.bt_pl;
              end
            end
            msg_len_o <= msg_len_o + 1'b1;
          end else begin
            msg_trunc_o <= 1'b1;
          end
        end
      end else if ((state == S_DELIVER) && msg_ready_i) begin
        msg_body_o     <= '0;
        msg_len_o      <= '0;
        msg_trunc_o    <= 1'b0;
        msg_misroute_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_noc_ejection_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_noc_ejection_unit                                         |
// | Description : Directed self-checking bench for noc_ejection_unit           |
// |               (LOCAL_X=2, LOCAL_Y=1, MAX_BODY=4).                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_noc_ejection_unit;
  import noc_pkg::*;

  localparam int MAXB = 4;
  localparam int FDS  = FLIT_DATA_SIZE;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic                          flit_valid_i = 1'b0;
  flit_novc_t                    flit = '0;
  logic [$bits(flit_novc_t)-1:0] flit_i;
  logic                          flit_ready_o;
  logic                          msg_valid_o;
  logic                          msg_ready_i = 1'b0;
  logic [3:0]                    msg_src_x_o;
  logic [3:0]                    msg_src_y_o;
  logic [63:0]                   msg_head_o;
  logic [MAXB*FDS-1:0]           msg_body_o;
  logic [2:0]                    msg_len_o;
  logic                          msg_trunc_o;
  logic                          msg_misroute_o;
  logic                          err_orphan_o;
  logic                          err_head_o;

  int checks = 0;
  int errors = 0;

  assign flit_i = flit;

  noc_ejection_unit #(.LOCAL_X(2), .LOCAL_Y(1), .MAX_BODY(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .flit_valid_i(flit_valid_i), .flit_i(flit_i), .flit_ready_o(flit_ready_o),
    .msg_valid_o(msg_valid_o), .msg_ready_i(msg_ready_i),
    .msg_src_x_o(msg_src_x_o), .msg_src_y_o(msg_src_y_o), .msg_head_o(msg_head_o),
    .msg_body_o(msg_body_o), .msg_len_o(msg_len_o), .msg_trunc_o(msg_trunc_o),
    .msg_misroute_o(msg_misroute_o), .err_orphan_o(err_orphan_o), .err_head_o(err_head_o)
  );

  always #5 clk = ~clk;

  function automatic flit_novc_t mk_head(input logic [1:0] t, input logic [3:0] dx, input logic [3:0] dy,
                                         input logic [3:0] sx, input logic [3:0] sy, input logic [63:0] d);
    flit_novc_t f;
    f.flit_type       = t;
    f.x_dest          = dx;
    f.y_dest          = dy;
    f.payload.head_pl = {sx, sy, d};
    return f;
  endfunction

  function automatic flit_novc_t mk_bt(input logic [1:0] t, input logic [71:0] d);
    flit_novc_t f;
    f.flit_type     = t;
    f.x_dest        = 4'd2;
    f.y_dest        = 4'd1;
    f.payload.bt_pl = d;
    return f;
  endfunction

  // Present one flit for one edge; returns #1 after that edge.
  task automatic send(input flit_novc_t f);
    flit_valid_i = 1'b1;
    flit = f;
    @(posedge clk); #1;
    flit_valid_i = 1'b0;
  endtask

  // Handshake the held message; returns #1 after the handshake edge.
  task automatic take_msg();
    msg_ready_i = 1'b1;
    @(posedge clk); #1;
    msg_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (flit_ready_o !== 1'b0 || msg_valid_o !== 1'b0) begin errors++; $display("FAIL reset_ctrl ready=%b valid=%b need 0 0", flit_ready_o, msg_valid_o); end
    checks++; if (msg_len_o !== 3'd0 || msg_body_o !== '0 || msg_head_o !== 64'd0 || msg_trunc_o !== 1'b0 ||
                  msg_misroute_o !== 1'b0 || err_orphan_o !== 1'b0 || err_head_o !== 1'b0 || msg_src_x_o !== 4'd0 || msg_src_y_o !== 4'd0) begin
      errors++; $display("FAIL reset_outputs len=%0d head=%h trunc=%b mis=%b need all 0", msg_len_o, msg_head_o, msg_trunc_o, msg_misroute_o); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (flit_ready_o !== 1'b0) begin errors++; $display("FAIL reset_release_ready got %b need 0", flit_ready_o); end
    @(posedge clk); #1;
    checks++; if (flit_ready_o !== 1'b1) begin errors++; $display("FAIL reset_first_edge_ready got %b need 1", flit_ready_o); end
  endtask

  task automatic test_headtail();
    send(mk_head(FLIT_HEADTAIL, 4'd2, 4'd1, 4'd5, 4'd3, 64'hDEADBEEF_00000001));
    checks++; if (msg_valid_o !== 1'b1 || flit_ready_o !== 1'b0) begin errors++; $display("FAIL ht_valid valid=%b ready=%b need 1 0", msg_valid_o, flit_ready_o); end
    checks++; if (msg_len_o !== 3'd0 || msg_misroute_o !== 1'b0) begin errors++; $display("FAIL ht_len_mis len=%0d mis=%b need 0 0", msg_len_o, msg_misroute_o); end
    checks++; if (msg_src_x_o !== 4'd5 || msg_src_y_o !== 4'd3) begin errors++; $display("FAIL ht_src got (%0d,%0d) need (5,3)", msg_src_x_o, msg_src_y_o); end
    checks++; if (msg_head_o !== 64'hDEADBEEF_00000001) begin errors++; $display("FAIL ht_head got %h need deadbeef00000001", msg_head_o); end
    take_msg();
    checks++; if (msg_valid_o !== 1'b0 || flit_ready_o !== 1'b1) begin errors++; $display("FAIL ht_release valid=%b ready=%b need 0 1", msg_valid_o, flit_ready_o); end
  endtask

  task automatic test_back_to_back();
    logic [MAXB*FDS-1:0] exp_body;
    exp_body = {72'h0, 72'h33, 72'h22, 72'h11};
    send(mk_head(FLIT_HEAD, 4'd2, 4'd1, 4'd1, 4'd2, 64'h0000_0000_0000_00AB));
    checks++; if (flit_ready_o !== 1'b1 || msg_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_collect ready=%b valid=%b need 1 0", flit_ready_o, msg_valid_o); end
    send(mk_bt(FLIT_BODY, 72'h11));
    send(mk_bt(FLIT_BODY, 72'h22));
    send(mk_bt(FLIT_TAIL, 72'h33));
    checks++; if (msg_valid_o !== 1'b1 || msg_len_o !== 3'd3) begin errors++; $display("FAIL b2b_len valid=%b len=%0d need 1 3", msg_valid_o, msg_len_o); end
    checks++; if (msg_body_o !== exp_body) begin errors++; $display("FAIL b2b_body got %h need %h", msg_body_o, exp_body); end
    // Offer a body flit while the message is held; it must not be taken.
    flit_valid_i = 1'b1;
    flit = mk_bt(FLIT_BODY, 72'h99);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (msg_valid_o !== 1'b1 || flit_ready_o !== 1'b0 || msg_len_o !== 3'd3 || msg_body_o !== exp_body ||
                    err_orphan_o !== 1'b0 || msg_head_o !== 64'hAB) begin
        errors++; $display("FAIL b2b_hold cyc=%0d valid=%b ready=%b len=%0d need 1 0 3", i, msg_valid_o, flit_ready_o, msg_len_o); end
    end
    flit_valid_i = 1'b0;
    take_msg();
    checks++; if (msg_valid_o !== 1'b0 || msg_len_o !== 3'd0 || msg_body_o !== '0) begin errors++; $display("FAIL b2b_clear valid=%b len=%0d need 0 0", msg_valid_o, msg_len_o); end
  endtask

  task automatic test_truncation();
    logic [MAXB*FDS-1:0] exp_body;
    exp_body = {72'h4, 72'h3, 72'h2, 72'h1};
    send(mk_head(FLIT_HEAD, 4'd2, 4'd1, 4'd0, 4'd0, 64'h5));
    for (int i = 1; i <= 5; i++) send(mk_bt(FLIT_BODY, 72'(i)));
    checks++; if (msg_trunc_o !== 1'b1 || msg_len_o !== 3'd4) begin errors++; $display("FAIL trunc_mid trunc=%b len=%0d need 1 4", msg_trunc_o, msg_len_o); end
    send(mk_bt(FLIT_TAIL, 72'h6));
    checks++; if (msg_valid_o !== 1'b1 || msg_len_o !== 3'd4 || msg_trunc_o !== 1'b1) begin errors++; $display("FAIL trunc_deliver valid=%b len=%0d trunc=%b need 1 4 1", msg_valid_o, msg_len_o, msg_trunc_o); end
    checks++; if (msg_body_o !== exp_body) begin errors++; $display("FAIL trunc_body got %h need %h", msg_body_o, exp_body); end
    take_msg();
    checks++; if (msg_trunc_o !== 1'b0) begin errors++; $display("FAIL trunc_clear got %b need 0", msg_trunc_o); end
  endtask

  task automatic test_orphan();
    send(mk_bt(FLIT_BODY, 72'h7));
    checks++; if (err_orphan_o !== 1'b1 || msg_valid_o !== 1'b0) begin errors++; $display("FAIL orphan_body err=%b valid=%b need 1 0", err_orphan_o, msg_valid_o); end
    send(mk_bt(FLIT_TAIL, 72'h8));
    checks++; if (err_orphan_o !== 1'b1 || msg_valid_o !== 1'b0 || flit_ready_o !== 1'b1) begin errors++; $display("FAIL orphan_tail err=%b valid=%b ready=%b need 1 0 1", err_orphan_o, msg_valid_o, flit_ready_o); end
    @(posedge clk); #1;
    checks++; if (err_orphan_o !== 1'b0 || msg_valid_o !== 1'b0) begin errors++; $display("FAIL orphan_pulse_end err=%b valid=%b need 0 0", err_orphan_o, msg_valid_o); end
    // Still in IDLE: a plain body must not be stored by a following head.
    send(mk_head(FLIT_HEADTAIL, 4'd2, 4'd1, 4'd0, 4'd0, 64'h0));
    checks++; if (msg_valid_o !== 1'b1 || msg_len_o !== 3'd0 || err_head_o !== 1'b0) begin errors++; $display("FAIL orphan_idle valid=%b len=%0d errh=%b need 1 0 0", msg_valid_o, msg_len_o, err_head_o); end
    take_msg();
  endtask

  task automatic test_restart_misroute();
    send(mk_head(FLIT_HEAD, 4'd2, 4'd1, 4'd1, 4'd1, 64'h1));
    send(mk_bt(FLIT_BODY, 72'hA));
    checks++; if (msg_len_o !== 3'd1) begin errors++; $display("FAIL restart_partial len=%0d need 1", msg_len_o); end
    send(mk_head(FLIT_HEADTAIL, 4'd3, 4'd1, 4'd6, 4'd7, 64'hCAFE));
    checks++; if (err_head_o !== 1'b1 || msg_valid_o !== 1'b1) begin errors++; $display("FAIL restart_errhead err=%b valid=%b need 1 1", err_head_o, msg_valid_o); end
    checks++; if (msg_len_o !== 3'd0 || msg_misroute_o !== 1'b1 || msg_body_o !== '0) begin errors++; $display("FAIL restart_msg len=%0d mis=%b need 0 1", msg_len_o, msg_misroute_o); end
    checks++; if (msg_src_x_o !== 4'd6 || msg_src_y_o !== 4'd7 || msg_head_o !== 64'hCAFE) begin errors++; $display("FAIL restart_head src=(%0d,%0d) head=%h need (6,7) cafe", msg_src_x_o, msg_src_y_o, msg_head_o); end
    @(posedge clk); #1;
    checks++; if (err_head_o !== 1'b0 || msg_valid_o !== 1'b1) begin errors++; $display("FAIL restart_pulse_end err=%b valid=%b need 0 1", err_head_o, msg_valid_o); end
    take_msg();
    checks++; if (msg_misroute_o !== 1'b0) begin errors++; $display("FAIL misroute_clear got %b need 0", msg_misroute_o); end
  endtask

  task automatic test_reset_mid_packet();
    send(mk_head(FLIT_HEAD, 4'd2, 4'd1, 4'd9, 4'd9, 64'h77));
    send(mk_bt(FLIT_BODY, 72'h55));
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (flit_ready_o !== 1'b0 || msg_valid_o !== 1'b0 || msg_len_o !== 3'd0 || msg_body_o !== '0 ||
                  msg_head_o !== 64'd0 || msg_src_x_o !== 4'd0 || msg_src_y_o !== 4'd0) begin
      errors++; $display("FAIL midrst_outputs ready=%b valid=%b len=%0d head=%h need 0 0 0 0", flit_ready_o, msg_valid_o, msg_len_o, msg_head_o); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (flit_ready_o !== 1'b1 || msg_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_recover ready=%b valid=%b need 1 0", flit_ready_o, msg_valid_o); end
    send(mk_head(FLIT_HEADTAIL, 4'd2, 4'd1, 4'd7, 4'd2, 64'h1234));
    checks++; if (msg_valid_o !== 1'b1 || msg_len_o !== 3'd0 || msg_misroute_o !== 1'b0 || msg_head_o !== 64'h1234) begin
      errors++; $display("FAIL midrst_msg valid=%b len=%0d mis=%b head=%h need 1 0 0 1234", msg_valid_o, msg_len_o, msg_misroute_o, msg_head_o); end
    take_msg();
  endtask

  initial begin
    test_reset();
    test_headtail();
    test_back_to_back();
    test_truncation();
    test_orphan();
    test_restart_misroute();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
